ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch and program-counter sequencer for the single-issue R/I/J CPU. It owns the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake. It presents each instruction to the control decoder, then consumes the decoder's 2-bit next-PC select to compute the following fetch address. It sits between instruction memory and the decoder, and also supplies the pc+4 link value used by jal.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- ACK_TIMEOUT, 15: maximum cycles FETCH waits for imem_ack before flagging an error. Range 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory has data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- inst  out  32  held instruction register.
- OP  out  6  inst[31:26], feeds the decoder.
- func  out  6  inst[5:0], feeds the decoder.
- inst_valid  out  1  inst/OP/func/pc are valid for issue.
- issue_ready  in  1  downstream accepts the current instruction.
- PC_s  in  2  next-PC select from the decoder: 00 = pc+4, 01 = register (jr), 10 = branch, 11 = jump.
- rs_data  in  32  jr target register value.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc+4, used as the jal link value.
- fetch_err  out  1  sticky; ack timeout occurred.
- align_err  out  1  sticky; misaligned next PC (see Configuration).

## Operation
- FSM states: RST, FETCH, ISSUE, HALT.
- RST: entered while rst_n=0. On the first clock after release, the FSM moves to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - Wait counter increments each cycle without ack.
  - On imem_ack=1: inst<=imem_rdata, counter<=0, next state ISSUE.
  - If the counter reaches ACK_TIMEOUT with no ack: fetch_err<=1, next state HALT.
- ISSUE:
  - inst_valid=1, imem_req=0.
  - Hold until inst_valid&issue_ready. PC_s and rs_data are sampled on that edge.
  - pc updates per PC_s, then next state FETCH.
- Next-PC arithmetic (32-bit, wrap modulo 2^32, carries discarded):
  - 00: pc+4.
  - 01: rs_data.
  - 10: pc+4 + (sign-extended inst[15:0] << 2).
  - 11: {pc_plus4[31:28], inst[25:0], 2'b00}.
- HALT: all handshake outputs are 0. The FSM stays in HALT until rst_n falls. Error flags hold.
- imem_ack outside FETCH is ignored. issue_ready outside ISSUE is ignored.
- OP, func and pc_plus4 are combinational from inst and pc.

## Timing
- Reset values:
  - pc=RESET_PC and inst=0, so OP=0 and func=0.
  - inst_valid=0, imem_req=0.
  - fetch_err=0, align_err=0.
  - pc_plus4=RESET_PC+4.
- Reset is asynchronous. Asserting rst_n mid-FETCH or mid-ISSUE immediately drops imem_req and inst_valid and restores all reset values.
- Minimum throughput is 2 cycles per instruction: 1 FETCH cycle with same-cycle ack, then 1 ISSUE cycle with issue_ready=1.
- imem_req rises on the first edge after rst_n release.
- inst_valid rises on the edge that captures the ack.
- The pc update and the return of imem_req both occur on the issue-handshake edge. The new imem_addr is visible in the following cycle.
- Timeout: the ack must arrive within ACK_TIMEOUT cycles of entering FETCH. An ack in cycle ACK_TIMEOUT is accepted; no ack in that cycle means HALT.
- PC_s is decoder-combinational from OP/func/ZF. It must be stable before the issue-handshake edge.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - At the issue handshake, if the computed next pc[1:0]!=00 (possible only for PC_s=01): align_err<=1, pc is not updated, next state HALT.
- PC_ALIGN_CHECK_EN undefined:
  - pc[1:0] is forced to 00 on every update.
  - align_err is tied to 0.

## Test plan
- Reset with RESET_PC=32'h100, ack same cycle, issue_ready=1, PC_s=00 for 3 instructions -> imem_addr sequence 100,104,108; 2 cycles per instruction; OP/func match fetched words.
- Branch: pc=0x200, inst=32'h1000_FFFF, PC_s=10 at handshake -> next imem_addr=0x200.
- Jump: pc=0xF000_0010, inst=32'h0800_0040, PC_s=11 -> next pc=0xF000_0100. jr with rs_data=0x400 and PC_s=01 -> next pc=0x400.
- Backpressure: hold issue_ready=0 for 5 cycles in ISSUE -> inst_valid stays 1, inst/pc stable, no imem_req. Release -> one pc advance only.
- Timeout with ACK_TIMEOUT=3 and no ack -> fetch_err=1 after 3 FETCH cycles, HALT. A late ack is ignored. rst_n pulse -> fetch_err=0, refetch at RESET_PC.
- With PC_ALIGN_CHECK_EN: jr rs_data=0x402 -> align_err=1, pc holds, HALT. Without the macro: next pc=0x400.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch / PC sequencer: fetches over imem req/ack, holds the word for issue,
// then steps the PC per the decoder's PC_s. Optional macro: PC_ALIGN_CHECK_EN.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [5:0]  OP,
    output logic [5:0]  func,
    output logic        inst_valid,
    input  logic        issue_ready,
    input  logic [1:0]  PC_s,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err,
    output logic        align_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [31:0]        pc_next_c;
    logic [31:0]        br_off;
    logic               ack_take;
    logic               issue_take;
    logic               timeout;
`ifdef PC_ALIGN_CHECK_EN
    logic               misalign_take;
`endif

    assign imem_addr = pc;
    assign OP        = inst[31:26];
    assign func      = inst[5:0];
    assign pc_plus4  = pc + 32'd4;
    assign br_off    = {{14{inst[15]}}, inst[15:0], 2'b00};

    // Next-PC candidate for the instruction currently held
    always_comb begin
        pc_next_c = pc_plus4;
        case (PC_s)
            2'b00:   pc_next_c = pc_plus4;
            2'b01:   pc_next_c = rs_data;
            2'b10:   pc_next_c = pc_plus4 + br_off;
            default: pc_next_c = {pc_plus4[31:28], inst[25:0], 2'b00};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RST;
        else        state <= state_nxt;
    end

    // Next-state and per-cycle event decode
    always_comb begin
        state_nxt  = state;
        ack_take   = 1'b0;
        issue_take = 1'b0;
        timeout    = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        misalign_take = 1'b0;
`endif
        case (state)
            ST_RST:   state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    ack_take  = 1'b1;
                    state_nxt = ST_ISSUE;
                end else if (wait_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = ST_HALT;
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    issue_take = 1'b1;
                    state_nxt  = ST_FETCH;
`ifdef PC_ALIGN_CHECK_EN
                    if (pc_next_c[1:0] != 2'b00) begin
                        issue_take    = 1'b0;
                        misalign_take = 1'b1;
                        state_nxt     = ST_HALT;
                    end
`endif
                end
            end
            default:  state_nxt = ST_HALT;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            inst       <= '0;
            wait_cnt   <= '0;
            fetch_err  <= 1'b0;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            imem_req   <= (state_nxt == ST_FETCH);
            inst_valid <= (state_nxt == ST_ISSUE);
            if (ack_take) inst <= imem_rdata;
            if ((state == ST_FETCH) && !imem_ack) wait_cnt <= wait_cnt + CNT_W'(1);
            else                                  wait_cnt <= '0;
            if (timeout) fetch_err <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            if (issue_take) pc <= pc_next_c;
`else
            if (issue_take) pc <= pc_next_c & ~32'h3;
`endif
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             align_err <= 1'b0;
        else if (misalign_take) align_err <= 1'b1;
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: cycle-level reference model plus directed program with literal expectations.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          TMO    = 3;
    localparam int          P_RST = 0, P_FETCH = 1, P_ISSUE = 2, P_HALT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic [5:0]  OP;
    logic [5:0]  func;
    logic        inst_valid;
    logic        issue_ready = 1'b0;
    logic [1:0]  PC_s = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(RST_PC), .ACK_TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .OP(OP), .func(func), .inst_valid(inst_valid), .issue_ready(issue_ready),
        .PC_s(PC_s), .rs_data(rs_data), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_err(fetch_err), .align_err(align_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: phase of the fetch/issue protocol plus architectural values
    int          m_phase = P_RST;
    int          m_wait  = 0;
    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_inst  = '0;
    logic        m_ferr  = 1'b0;
    logic        m_aerr  = 1'b0;

    function automatic logic [31:0] target(input logic [31:0] cur, input logic [31:0] w,
                                           input logic [1:0] sel, input logic [31:0] rs);
        int off;
        off = int'($signed(w[15:0]));
        case (sel)
            2'd0:    return cur + 32'd4;
            2'd1:    return rs;
            2'd2:    return cur + 32'd4 + 32'(off * 4);
            default: return ((cur + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] t;
        if (!rst_n) begin
            m_phase = P_RST; m_wait = 0; m_pc = RST_PC; m_inst = '0; m_ferr = 1'b0; m_aerr = 1'b0;
        end else begin
            case (m_phase)
                P_RST: begin m_phase = P_FETCH; m_wait = 0; end
                P_FETCH: begin
                    if (imem_ack) begin
                        m_inst = imem_rdata; m_phase = P_ISSUE;
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin m_ferr = 1'b1; m_phase = P_HALT; end
                    end
                end
                P_ISSUE: begin
                    if (issue_ready) begin
                        t = target(m_pc, m_inst, PC_s, rs_data);
`ifdef PC_ALIGN_CHECK_EN
                        if (t % 4 != 0) begin
                            m_aerr = 1'b1; m_phase = P_HALT;
                        end else begin
                            m_pc = t; m_phase = P_FETCH; m_wait = 0;
                        end
`else
                        m_pc = t - (t % 4); m_phase = P_FETCH; m_wait = 0;
`endif
                    end
                end
                default: m_phase = P_HALT;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("imem_req",   imem_req,   32'(m_phase == P_FETCH));
        chk("inst_valid", inst_valid, 32'(m_phase == P_ISSUE));
        chk("imem_addr",  imem_addr,  m_pc);
        chk("pc",         pc,         m_pc);
        chk("pc_plus4",   pc_plus4,   m_pc + 32'd4);
        chk("inst",       inst,       m_inst);
        chk("OP",         32'(OP),    m_inst >> 26);
        chk("func",       32'(func),  m_inst % 64);
        chk("fetch_err",  fetch_err,  m_ferr);
        chk("align_err",  align_err,  m_aerr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin step(); n++; end
        chk("wait_req", imem_req, 1);
    endtask

    task automatic do_fetch(input logic [31:0] word, input int delay);
        wait_req();
        imem_ack = 1'b0;
        repeat (delay) step();
        imem_ack = 1'b1; imem_rdata = word;
        step();
        imem_ack = 1'b0;
    endtask

    task automatic do_issue(input logic [1:0] sel, input logic [31:0] rs, input int stall);
        issue_ready = 1'b0;
        repeat (stall) step();
        issue_ready = 1'b1; PC_s = sel; rs_data = rs;
        step();
        issue_ready = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_req",   imem_req,   0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_pc",    pc,         32'h100);
        chk("rst_p4",    pc_plus4,   32'h104);
        chk("rst_inst",  inst,       0);
        chk("rst_ferr",  fetch_err,  0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("init_pc", pc, 32'h100);
        chk("init_OP", 32'(OP), 0);
        rst_n = 1'b1;
        step();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h100);

        // Sequential flow, 2 cycles per instruction
        do_fetch(32'h2001_0005, 0);
        chk("lit_OP", 32'(OP), 32'h08);
        chk("lit_func", 32'(func), 32'h05);
        do_issue(2'b00, 0, 0);
        chk("seq_addr1", imem_addr, 32'h104);
        chk("seq_req1", imem_req, 1);
        do_fetch(32'h0022_1820, 0);
        do_issue(2'b00, 0, 0);
        chk("seq_addr2", imem_addr, 32'h108);

        // jr to 0x200, then branch-to-self at 0x200
        do_fetch(32'h0000_0008, 0);
        do_issue(2'b01, 32'h200, 0);
        chk("jr_200", imem_addr, 32'h200);
        do_fetch(32'h1000_FFFF, 0);
        do_issue(2'b10, 0, 0);
        chk("branch_self", imem_addr, 32'h200);

        // Jump keeps upper nibble of pc+4
        do_fetch(32'h0040_0008, 0);
        do_issue(2'b01, 32'hF000_0010, 0);
        do_fetch(32'h0800_0040, 0);
        do_issue(2'b11, 0, 0);
        chk("jump", pc, 32'hF000_0100);
        do_fetch(32'h0000_0008, 0);
        do_issue(2'b01, 32'h400, 0);
        chk("jr_400", pc, 32'h400);

        // Ack at the last allowed cycle, then 5 cycles of backpressure
        do_fetch(32'h2000_0001, TMO - 1);
        chk("late_ack_ok", inst_valid, 1);
        do_issue(2'b00, 0, 5);
        chk("bp_advance", pc, 32'h404);

        // Misaligned jr
        do_fetch(32'h0000_0008, 0);
        do_issue(2'b01, 32'h402, 0);
`ifdef PC_ALIGN_CHECK_EN
        chk("align_err", align_err, 1);
        chk("align_pc", pc, 32'h404);
        chk("align_halt", imem_req, 0);
`else
        chk("align_force", pc, 32'h400);
        chk("align_none", align_err, 0);
`endif
        step();

        // Reset mid-cycle, then fetch timeout
        #2;
        reset_pulse();
        wait_req();
        imem_ack = 1'b0;
        repeat (TMO) step();
        chk("tmo_ferr", fetch_err, 1);
        chk("tmo_halt", imem_req, 0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        repeat (2) step();
        imem_ack = 1'b0;
        chk("halt_ignore", inst_valid, 0);
        chk("halt_inst", inst, 0);

        reset_pulse();
        step();
        chk("refetch_addr", imem_addr, 32'h100);
        do_fetch(32'h0022_1820, 0);
        do_issue(2'b00, 0, 0);
        chk("refetch_next", pc, 32'h104);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
